clk_period_meas: RTL and testbench
==================================

Name: clk_period_meas

Overview:
- Receive-side counterpart of the programmable clock divider: samples an asynchronous square wave on IN and recovers the divider setting T, i.e. GCLK cycles per half-period minus one.
- Used to check SPI serial clocks and other divided clocks generated elsewhere in the design, and to auto-detect the rate of an incoming serial clock.
- Reports each measurement with a one-cycle strobe, asserts a lock flag when consecutive measurements agree, and flags loss of the input.

Parameters:
- W, 64, width of T_OUT and of the internal cycle counter.
- SYNC_STAGES, 2, synchronizer flops on IN; legal values are 2 or more.
- TIMEOUT_CYCLES, 2**32, number of GCLK cycles without an edge before TIMEOUT asserts; must be less than 2**W.
- LOCK_COUNT, 2, number of consecutive matching measurements required to assert LOCKED; must be 1 or more.
- TOL, 0, maximum absolute difference between two measurements for them to count as matching.

Ports:
- GCLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  1  asynchronous square wave to be measured.
- T_OUT  out  W  most recent half-period measurement, expressed as cycles minus 1.
- VALID  out  1  one-cycle strobe; T_OUT updated this cycle.
- LOCKED  out  1  level; last LOCK_COUNT measurements agree within TOL.
- TIMEOUT  out  1  level; no edge seen for TIMEOUT_CYCLES.

Behaviour:
- Reset values: T_OUT=0, VALID=0, LOCKED=0, TIMEOUT=0. All synchronizer flops, the edge-history flop, cnt and match_cnt clear to 0. State goes to IDLE.
- RST held mid-measurement discards any partial count. The first edge after release is treated as a first edge and produces no VALID.
- Synchronizer: s[0]<=IN, s[i]<=s[i-1]; prev<=s[SYNC_STAGES-1].
- Edge detection: edge = s[SYNC_STAGES-1] XOR prev. Rising and falling edges are treated the same.
- Latency: an IN transition first sampled at GCLK edge k produces a registered VALID/T_OUT update at edge k+SYNC_STAGES.
- Counter, on an edge cycle: cnt<=0.
- Counter, otherwise: cnt<=cnt+1, held at TIMEOUT_CYCLES-1 with no wrap.
- Measurement rule: two edges N cycles apart give T_OUT=N-1. A divider programmed with T gives T_OUT=T.
- State IDLE (after reset or timeout):
  - On an edge: go to ARMED, clear TIMEOUT, do not assert VALID.
  - T_OUT keeps its last value.
- State ARMED, on an edge:
  - T_OUT<=cnt; VALID=1 for one cycle.
  - prev_meas<=cnt.
  - Match evaluation (compares against the prior prev_meas):
    - If this is the first measurement since IDLE, match_cnt<=1.
    - Else if |cnt-prev_meas|<=TOL, match_cnt<=min(match_cnt+1, LOCK_COUNT).
    - Else match_cnt<=1.
  - LOCKED<=(new match_cnt>=LOCK_COUNT). A mismatch drops LOCKED in the same cycle as VALID.
- State ARMED, no edge and cnt==TIMEOUT_CYCLES-1:
  - TIMEOUT<=1, LOCKED<=0, match_cnt<=0, go to IDLE.
  - No VALID; T_OUT is held.
- Timeout takes priority check: an edge arriving in the same cycle cnt reaches TIMEOUT_CYCLES-1 is a valid measurement (T_OUT=TIMEOUT_CYCLES-1) and timeout does not fire.
- Edges on consecutive cycles (the fastest possible input) give T_OUT=0 on every cycle, with VALID held high continuously.
- The |a-b| comparison is done in W+1 bits, so there is no wrap-around error.
- IN is never used combinationally downstream of the synchronizer.

Test Plan:
- Drive IN from the divider model with T=5 (toggle every 6 GCLK), RST released:
  - First edge gives no VALID; every 6 cycles after that, VALID=1 with T_OUT=5.
  - LOCKED=1 at the 2nd VALID.
  - Check the SYNC_STAGES+1 latency relative to the IN transition.
- T=0 (IN toggles every cycle):
  - After the first edge, VALID stays 1 continuously, T_OUT=0, LOCKED=1.
- Running locked at T=5, switch to T=9:
  - First VALID with T_OUT=9 has LOCKED=0 in the same cycle.
  - LOCKED returns to 1 at the next T_OUT=9 measurement.
- TIMEOUT_CYCLES=100, stop toggling IN after locking at T=5:
  - TIMEOUT=1 and LOCKED=0 exactly 100 cycles after the last edge; T_OUT stays 5.
  - Restarting IN: TIMEOUT clears on the first edge, VALID only from the second edge onward.
- Assert RST for 1 cycle midway through a T=7 half-period:
  - All outputs read 0 the next cycle.
  - The next edge gives no VALID; the following edge gives T_OUT=7.
- TOL=1, alternate half-periods of 6 and 7 cycles (T_OUT 5/6):
  - LOCKED=1 after 2 measurements.
  - Repeat with TOL=0: LOCKED never asserts.

Source files
------------

// File: rtl/clk_period_meas_if.sv
// Bundles the sampled square wave and the period measurement results.
// master: the measuring block; slave: whoever drives IN and consumes results.
interface clk_period_meas_if #(
  parameter int unsigned W = 64
);
  logic         IN;
  logic [W-1:0] T_OUT;
  logic         VALID;
  logic         LOCKED;
  logic         TIMEOUT;

  modport master (input IN, output T_OUT, VALID, LOCKED, TIMEOUT);
  modport slave  (output IN, input T_OUT, VALID, LOCKED, TIMEOUT);
endinterface

// File: rtl/clk_period_meas.sv
// Recovers the divider setting T (GCLK cycles per half-period minus one) of an
// asynchronous square wave, with lock detection across measurements and loss-of-input timeout.
module clk_period_meas #(
  parameter int unsigned     W              = 64,
  parameter int unsigned     SYNC_STAGES    = 2,
  parameter longint unsigned TIMEOUT_CYCLES = 64'h1_0000_0000,
  parameter int unsigned     LOCK_COUNT     = 2,
  parameter int unsigned     TOL            = 0
) (
  input logic               GCLK,
  input logic               RST,
  clk_period_meas_if.master bus
);
  localparam int unsigned   MW      = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  CNT_MAX = W'(TIMEOUT_CYCLES - 64'd1);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_COUNT);
  localparam logic [W:0]    TOL_W   = (W+1)'(TOL);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [W-1:0]           cnt;
  logic [W-1:0]           t_out_q, t_out_d;
  logic [W-1:0]           prev_meas_q, prev_meas_d;
  logic [MW-1:0]          match_q, match_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   edge_c;
  logic [W:0]             diff_c;
  logic [W:0]             abs_diff_c;

  assign edge_c = sync[SYNC_STAGES-1] ^ prev;

  // Synchronizer, edge history and saturating cycle counter.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.IN};
      prev <= sync[SYNC_STAGES-1];
      if (edge_c)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q     <= IDLE;
      t_out_q     <= '0;
      prev_meas_q <= '0;
      match_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_out_q     <= t_out_d;
      prev_meas_q <= prev_meas_d;
      match_q     <= match_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  // Extra bit keeps the difference free of wrap-around.
  always_comb begin
    diff_c     = {1'b0, cnt} - {1'b0, prev_meas_q};
    abs_diff_c = diff_c[W] ? -diff_c : diff_c;
  end

  // Next state; an edge wins over a timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    t_out_d     = t_out_q;
    prev_meas_d = prev_meas_q;
    match_d     = match_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (edge_c) begin
          state_d   = ARMED;
          timeout_d = 1'b0;
        end
      end
      ARMED: begin
        if (edge_c) begin
          t_out_d     = cnt;
          valid_d     = 1'b1;
          prev_meas_d = cnt;
          if (match_q == '0)
            match_d = MW'(1);
          else if (abs_diff_c <= TOL_W)
            match_d = (match_q >= LOCK_N) ? LOCK_N : match_q + MW'(1);
          else
            match_d = MW'(1);
          locked_d = (match_d >= LOCK_N);
        end else if (cnt == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.T_OUT   = t_out_q;
  assign bus.VALID   = valid_q;
  assign bus.LOCKED  = locked_q;
  assign bus.TIMEOUT = timeout_q;
endmodule

// File: tb/tb_clk_period_meas.sv
// Directed bench for clk_period_meas: two instances share IN, one with TOL=0 and one with TOL=1.
module tb_clk_period_meas;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_sig;
  int   n_checks = 0;
  int   n_fail   = 0;

  clk_period_meas_if #(.W(W)) bus0 ();
  clk_period_meas_if #(.W(W)) bus1 ();

  assign bus0.IN = in_sig;
  assign bus1.IN = in_sig;

  clk_period_meas #(.W(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .LOCK_COUNT(2), .TOL(0))
    dut0 (.GCLK(clk), .RST(rst), .bus(bus0));
  clk_period_meas #(.W(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .LOCK_COUNT(2), .TOL(1))
    dut1 (.GCLK(clk), .RST(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle IN, check the result SYNC_STAGES+1 edges later, then idle out the half-period.
  task automatic toggle(input string tag, input int wait_after, input logic exp_v,
                        input logic [W-1:0] exp_t, input logic exp_l0, input logic exp_l1,
                        input logic exp_to);
    in_sig = ~in_sig;
    tick(2);
    check({tag, ".early_valid"}, W'(bus0.VALID), W'(1'b0));
    tick(1);
    check({tag, ".valid0"},   W'(bus0.VALID),   W'(exp_v));
    check({tag, ".valid1"},   W'(bus1.VALID),   W'(exp_v));
    check({tag, ".t_out0"},   bus0.T_OUT,       exp_t);
    check({tag, ".t_out1"},   bus1.T_OUT,       exp_t);
    check({tag, ".locked0"},  W'(bus0.LOCKED),  W'(exp_l0));
    check({tag, ".locked1"},  W'(bus1.LOCKED),  W'(exp_l1));
    check({tag, ".timeout0"}, W'(bus0.TIMEOUT), W'(exp_to));
    tick(wait_after - 3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".t_out0"},   bus0.T_OUT,       '0);
    check({tag, ".valid0"},   W'(bus0.VALID),   '0);
    check({tag, ".locked0"},  W'(bus0.LOCKED),  '0);
    check({tag, ".timeout0"}, W'(bus0.TIMEOUT), '0);
    check({tag, ".t_out1"},   bus1.T_OUT,       '0);
    check({tag, ".locked1"},  W'(bus1.LOCKED),  '0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    check_zero("reset_pulse");
    rst = 1'b0;
    tick(3);
  endtask

  initial begin
    rst    = 1'b1;
    in_sig = 1'b0;
    tick(3);
    check_zero("por");
    rst = 1'b0;
    tick(2);

    // T=5 from IDLE
    toggle("t5_first", 6, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    toggle("t5_m1",    6, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    toggle("t5_m2",    6, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    toggle("t5_m3",    6, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0);

    // switch to T=9 while locked
    toggle("t9_pre", 10, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    toggle("t9_m1",  10, 1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
    toggle("t9_m2",  10, 1'b1, 16'd9, 1'b1, 1'b1, 1'b0);
    toggle("t9_m3",   6, 1'b1, 16'd9, 1'b1, 1'b1, 1'b0);

    // back to T=5, then stop the input
    toggle("t5b_m1", 6, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    toggle("t5b_m2", 3, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    tick(99);
    check("to_early.timeout", W'(bus0.TIMEOUT), '0);
    check("to_early.locked",  W'(bus0.LOCKED),  W'(1'b1));
    tick(1);
    check("to.timeout0", W'(bus0.TIMEOUT), W'(1'b1));
    check("to.timeout1", W'(bus1.TIMEOUT), W'(1'b1));
    check("to.locked0",  W'(bus0.LOCKED),  '0);
    check("to.valid0",   W'(bus0.VALID),   '0);
    check("to.t_out0",   bus0.T_OUT,       16'd5);
    tick(5);

    // restart after timeout
    toggle("restart_first", 6, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0);
    toggle("restart_m1",    6, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    toggle("restart_m2",    8, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    toggle("t7_m1",         4, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);

    // reset midway through a T=7 half-period
    pulse_reset();
    toggle("post_rst_first", 8, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    toggle("post_rst_m1",    6, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);

    // alternating 6/7-cycle half-periods: only the TOL=1 instance locks
    pulse_reset();
    toggle("tol_first", 6, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    toggle("tol_m1",    7, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    toggle("tol_m2",    6, 1'b1, 16'd6, 1'b0, 1'b1, 1'b0);
    toggle("tol_m3",    7, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
    toggle("tol_m4",    6, 1'b1, 16'd6, 1'b0, 1'b1, 1'b0);
    toggle("tol_m5",    3, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0);

    // T=0: IN toggles every cycle
    pulse_reset();
    for (int i = 1; i <= 20; i++) begin
      in_sig = ~in_sig;
      tick(1);
      if (i == 3) begin
        check("t0_first.valid", W'(bus0.VALID), '0);
      end else if (i == 4) begin
        check("t0_m1.valid",  W'(bus0.VALID),  W'(1'b1));
        check("t0_m1.t_out",  bus0.T_OUT,      '0);
        check("t0_m1.locked", W'(bus0.LOCKED), '0);
      end else if (i >= 5) begin
        check("t0_run.valid",   W'(bus0.VALID),  W'(1'b1));
        check("t0_run.t_out",   bus0.T_OUT,      '0);
        check("t0_run.locked0", W'(bus0.LOCKED), W'(1'b1));
        check("t0_run.locked1", W'(bus1.LOCKED), W'(1'b1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
